// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Bit-counter width; a 1-bit floor keeps the counter legal at the smallest width.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single combinational full-adder cell
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - WIDTH-bit adder processing one bit per clock, LSB first
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             c_msb_in;
   logic             cell_s;
   logic             cell_co;
   logic             load;
   logic             step;
   logic             last_bit;

   assign last_bit = (cnt == LAST);

   full_adder u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_bit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      load = 1'b0;
      step = 1'b0;
      case (state)
         IDLE: load = start;
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
         end
         default: ;
      endcase
   end

   // Result registers only move on the final bit so the previous answer stays visible during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         sum_sh   <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (step) begin
            sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
            carry  <= cell_co;
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            if (cnt == PRE) begin
               c_msb_in <= cell_co;
            end
            if (last_bit) begin
               sum  <= {cell_s, sum_sh[WIDTH-1:1]};
               cout <= cell_co;
               ovf  <= c_msb_in ^ cell_co;
               done <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a load edge; on return the sample after E0 is current.
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      a = av;
      b = bv;
      cin = ci;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Bounded wait for done; counts samples with busy high along the way.
   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) cyc++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      cin = 1'b0;
      #12;
      checks++;
      if ({busy, done, sum, cout, ovf} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
      end
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_zero();
      int cyc;
      bit ok;
      start_op(8'h00, 8'h00, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_busy_after_load got %b want 1", busy);
      end
      wait_done(cyc, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL zero_done_timeout got no done want done");
      end
      checks++;
      if (cyc !== 8) begin
         errors++;
         $display("FAIL zero_busy_cycles got %0d want 8", cyc);
      end
      checks++;
      if ({busy, sum, cout, ovf} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL zero_result got busy=%b sum=%h cout=%b ovf=%b want 0 00 0 0", busy, sum, cout, ovf);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_done_pulse_width got %b want 0", done);
      end
   endtask

   task automatic test_carry_out();
      int cyc;
      bit ok;
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc !== 8 || {sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL carry_out got ok=%b cyc=%0d sum=%h cout=%b ovf=%b want 1 8 00 1 0", ok, cyc, sum, cout, ovf);
      end
      tick();
   endtask

   task automatic test_overflow();
      int cyc;
      bit ok;
      start_op(8'h7F, 8'h01, 1'b0);
      wait_done(cyc, ok);
      checks++;
      if (!ok || {sum, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL overflow got ok=%b sum=%h cout=%b ovf=%b want 1 80 0 1", ok, sum, cout, ovf);
      end
      tick();
   endtask

   task automatic test_negative_cin();
      int cyc;
      bit ok;
      start_op(8'h80, 8'hFF, 1'b1);
      wait_done(cyc, ok);
      checks++;
      if (!ok || {sum, cout, ovf} !== {8'h80, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL neg_cin got ok=%b sum=%h cout=%b ovf=%b want 1 80 1 0", ok, sum, cout, ovf);
      end
      tick();
   endtask

   task automatic test_ignore_start();
      int cyc;
      bit ok;
      start_op(8'h3C, 8'h0F, 1'b0);
      tick();
      tick();
      a = 8'hFF;
      b = 8'hAA;
      cin = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || sum !== 8'h80 || cout !== 1'b1) begin
         errors++;
         $display("FAIL ignore_hold_prior got busy=%b sum=%h cout=%b want 1 80 1", busy, sum, cout);
      end
      wait_done(cyc, ok);
      checks++;
      if (!ok || {sum, cout, ovf} !== {8'h4B, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL ignore_result got ok=%b sum=%h cout=%b ovf=%b want 1 4b 0 0", ok, sum, cout, ovf);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_no_restart got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      start_op(8'hFF, 8'hFF, 1'b1);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, cout, ovf} !== 11'd0) begin
         errors++;
         $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
      end
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL midrun_no_done got %0d pulses want 0", dones);
      end
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit ok;
      start_op(8'h12, 8'h34, 1'b0);
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc !== 8 || sum !== 8'h46 || cout !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first got ok=%b cyc=%0d sum=%h cout=%b want 1 8 46 0", ok, cyc, sum, cout);
      end
      start_op(8'h01, 8'h02, 1'b1);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done);
      end
      wait_done(cyc, ok);
      checks++;
      if (!ok || cyc !== 8 || {sum, cout, ovf} !== {8'h04, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second got ok=%b cyc=%0d sum=%h cout=%b ovf=%b want 1 8 04 0 0", ok, cyc, sum, cout, ovf);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_zero();
      test_carry_out();
      test_overflow();
      test_negative_cin();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Parametrised bit-serial adder; successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first, through one full-adder cell and a registered carry.
- Start/busy/done handshake; returns WIDTH-bit sum, carry-out and signed-overflow flag.
- Sits beside the combinational adders as the low-area option for wide operands.

## Interface

- WIDTH, 8, operand/sum width in bits; legal range 2..64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- busy  out  1  addition in progress
- done  out  1  one-cycle pulse; result registers just updated
- sum  out  WIDTH  result, held until the next completion
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation

- States: IDLE, RUN.
- IDLE, start=1:
  - Load a and b into operand shift registers; load cin into the carry flop.
  - Clear the bit counter; busy<=1; enter RUN.
- IDLE, start=0: hold.
- RUN, each edge:
  - Full-adder cell takes a_sh[0], b_sh[0] and carry.
  - Sum bit shifts into the MSB of the internal sum shift register.
  - Carry flop takes the cell carry.
  - Operand registers shift right; counter increments.
- Bit index WIDTH-2: capture the carry out of that bit as c_msb_in.
- Final edge (bit index WIDTH-1):
  - Copy the internal sum register, including the final bit, to sum.
  - cout <= cell carry; ovf <= c_msb_in XOR cell carry.
  - done<=1; busy<=0; return to IDLE.
- start while busy=1 is ignored. a, b and cin may change freely after the load edge.
- sum, cout and ovf do not change during RUN; they keep the previous result.
- Counter width is $clog2(WIDTH). The counter never wraps: the terminal count ends RUN.

## Timing

- Reset values:
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - State IDLE; internal shift registers, carry and counter all 0.
- Load edge E0 (start sampled high in IDLE): busy goes high after E0.
- Bit i is processed at edge E(i+1), for i = 0..WIDTH-1.
- At E(WIDTH): sum, cout and ovf update, done rises and busy falls.
  - busy is high for exactly WIDTH cycles.
  - Latency from the start edge to the done cycle is WIDTH cycles.
- done falls at E(WIDTH+1) unless a new operation completes then. That cannot happen, because every operation needs WIDTH ≥ 2 cycles.
- Back-to-back: start high during the done cycle is accepted at E(WIDTH+1). Throughput is one result per WIDTH+1 cycles.
- Reset asserted mid-RUN:
  - All outputs and state go immediately to reset values.
  - No done pulse; the partial result is discarded.
- Reset released: the first active edge behaves as an IDLE edge.

## Structure

- Package serial_adder_pkg:
  - state enum (IDLE, RUN)
  - default WIDTH constant
  - localparam function for the counter width
- Sub-module full_adder: purely combinational (x, y, ci -> s, co), instantiated once. It is the only arithmetic in the block.
- Everything else (FSM, shift registers, counter, result registers) lives in serial_adder.

## Test plan

All scenarios use WIDTH=8.

- Reset, then a=0x00, b=0x00, cin=0, start pulse:
  - busy high 8 cycles.
  - done pulse in cycle 8 with sum=0x00, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- a=0x80, b=0xFF, cin=1 -> sum=0x80, cout=1, ovf=0.
- a=0x3C, b=0x0F, cin=0: during RUN, pulse start with a=0xFF and change a and b.
  - The extra start is ignored.
  - Result sum=0x4B, cout=0; sum holds the prior result until done.
- rst_n low at cycle 4 of an operation:
  - Outputs go to 0 immediately; no done pulse.
  - The next operation a=0x12, b=0x34, cin=0, with start held high on its done cycle, produces sum=0x46.
  - The back-to-back operation starts on the next edge.
